// File: rtl/tr_lights_pkg.sv
// tr_lights_pkg: shared definitions for the multi-phase traffic light controller.
//   - state_e      : controller state codes (GREEN/YELLOW/ALLRED/FLASH)
//   - lamp codes   : per-phase lamp encoding (RED/YELLOW/GREEN/OFF)
//   - PhaseW       : width of the phase index
//   - next_phase() : fixed-time rotation helper
package tr_lights_pkg;

    localparam int unsigned PhaseW = 2;

    typedef enum logic [1:0] {
        StGreen  = 2'b00,
        StYellow = 2'b01,
        StAllred = 2'b10,
        StFlash  = 2'b11
    } state_e;

    typedef logic [1:0] lamp_t;

    localparam lamp_t LampRed    = 2'b00;
    localparam lamp_t LampYellow = 2'b01;
    localparam lamp_t LampGreen  = 2'b10;
    localparam lamp_t LampOff    = 2'b11;

    // (p + 1) mod n
    function automatic logic [PhaseW-1:0] next_phase(input logic [PhaseW-1:0] p,
                                                     input int unsigned       n);
        if (32'(p) + 32'd1 >= n) begin
            return '0;
        end
        return PhaseW'(32'(p) + 32'd1);
    endfunction

endpackage

// File: rtl/tr_dwell_timer.sv
// tr_dwell_timer: prescaler plus dwell counter for one controller state.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   restart - clears prescaler and dwell counter (state entry)
//   limit   - dwell length T in ticks (>= 1)
//   tick    - prescaler is at TICK_DIV-1 this cycle
//   done    - tick on which the dwell counter equals limit-1 (state exit)
module tr_dwell_timer #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned CntW     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic [CntW-1:0] limit,
    output logic            tick,
    output logic            done
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PreW-1:0] r_pre;
    logic [CntW-1:0] r_cnt;

    assign tick = (r_pre == PreW'(TICK_DIV - 1));
    assign done = tick && (r_cnt == (limit - CntW'(1)));

    // restart has priority so the exit tick clears rather than increments
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (restart) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (tick) begin
            r_pre <= '0;
            r_cnt <= r_cnt + CntW'(1);
        end else begin
            r_pre <= r_pre + PreW'(1);
        end
    end

endmodule

// File: rtl/tr_lights_multi.sv
// tr_lights_multi: N-phase traffic light controller with night flashing mode.
// Ports:
//   clk     - clock, all state changes on rising edge
//   rst     - asynchronous active-high reset
//   flash   - night flashing request, honoured only at ALLRED exit or in FLASH
//   veh_req - per-phase vehicle demand (used only with TRL_DEMAND_EN)
//   lights  - lamp code of phase i at [2i+1:2i]
//   phase   - phase currently owning right of way
//   state   - controller state code
// Build option: define TRL_DEMAND_EN for demand-actuated phase selection;
// otherwise rotation is fixed-time and veh_req is ignored.
module tr_lights_multi
    import tr_lights_pkg::*;
#(
    parameter int unsigned N_PHASES = 2,
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned GREEN_T  = 5,
    parameter int unsigned YELLOW_T = 1,
    parameter int unsigned ALLRED_T = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flash,
    input  logic [N_PHASES-1:0]   veh_req,
    output logic [2*N_PHASES-1:0] lights,
    output logic [1:0]            phase,
    output logic [1:0]            state
);

    localparam int unsigned MaxGy = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int unsigned MaxT  = (MaxGy > ALLRED_T) ? MaxGy : ALLRED_T;
    localparam int unsigned CntW  = $clog2(MaxT + 1);

    state_e            r_state, w_state_d;
    logic [PhaseW-1:0] r_phase, w_phase_d;
    logic              r_blink, w_blink_d;
    // ALLRED entered from FLASH must hand over to phase 0, not phase+1
    logic              r_recover, w_recover_d;

    logic              w_restart;
    logic              w_enter_green;
    logic              w_tick;
    logic              w_done;
    logic [CntW-1:0]   w_limit;
    logic [PhaseW-1:0] w_next_phase;

    tr_dwell_timer #(
        .TICK_DIV (TICK_DIV),
        .CntW     (CntW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .limit   (w_limit),
        .tick    (w_tick),
        .done    (w_done)
    );

    always_comb begin
        w_limit = CntW'(1);
        unique case (r_state)
            StGreen:  w_limit = CntW'(GREEN_T);
            StYellow: w_limit = CntW'(YELLOW_T);
            StAllred: w_limit = CntW'(ALLRED_T);
            StFlash:  w_limit = CntW'(1);
            default:  w_limit = CntW'(1);
        endcase
    end

`ifdef TRL_DEMAND_EN
    logic [N_PHASES-1:0] r_req;
    logic [N_PHASES-1:0] w_clr;

    // Scan offsets from N down to 1 so the nearest requesting phase wins.
    always_comb begin
        w_next_phase = next_phase(r_phase, N_PHASES);
        for (int k = N_PHASES; k >= 1; k--) begin
            for (int j = 0; j < N_PHASES; j++) begin
                if (r_req[j] && (32'(j) == ((32'(r_phase) + 32'(k)) % N_PHASES))) begin
                    w_next_phase = PhaseW'(j);
                end
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int j = 0; j < N_PHASES; j++) begin
            w_clr[j] = w_enter_green && (w_phase_d == PhaseW'(j));
        end
    end

    // A request arriving on the clearing cycle survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else begin
            r_req <= (r_req & ~w_clr) | veh_req;
        end
    end
`else
    logic w_unused_veh;
    assign w_unused_veh = ^veh_req;

    always_comb begin
        w_next_phase = next_phase(r_phase, N_PHASES);
    end
`endif

    always_comb begin
        w_state_d     = r_state;
        w_phase_d     = r_phase;
        w_blink_d     = r_blink;
        w_recover_d   = r_recover;
        w_restart     = 1'b0;
        w_enter_green = 1'b0;
        unique case (r_state)
            StGreen: begin
                if (w_done) begin
                    w_state_d = StYellow;
                    w_restart = 1'b1;
                end
            end
            StYellow: begin
                if (w_done) begin
                    w_state_d = StAllred;
                    w_restart = 1'b1;
                end
            end
            StAllred: begin
                if (w_done) begin
                    w_restart   = 1'b1;
                    w_recover_d = 1'b0;
                    if (flash) begin
                        w_state_d = StFlash;
                        w_phase_d = '0;
                        w_blink_d = 1'b1;  // flashing starts with the yellow half
                    end else begin
                        w_state_d     = StGreen;
                        w_phase_d     = r_recover ? '0 : w_next_phase;
                        w_enter_green = 1'b1;
                    end
                end
            end
            StFlash: begin
                // Restart each tick so the dwell counter never runs in FLASH
                if (w_tick) begin
                    w_restart = 1'b1;
                    if (!flash) begin
                        w_state_d   = StAllred;
                        w_phase_d   = '0;
                        w_blink_d   = 1'b0;
                        w_recover_d = 1'b1;
                    end else begin
                        w_blink_d = ~r_blink;
                    end
                end
            end
            default: w_state_d = StGreen;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StGreen;
            r_phase   <= '0;
            r_blink   <= 1'b0;
            r_recover <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_phase   <= w_phase_d;
            r_blink   <= w_blink_d;
            r_recover <= w_recover_d;
        end
    end

    // Lamp decode from registered state only
    always_comb begin
        lights = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            unique case (r_state)
                StGreen: begin
                    if (r_phase == PhaseW'(i)) lights[2*i +: 2] = LampGreen;
                end
                StYellow: begin
                    if (r_phase == PhaseW'(i)) lights[2*i +: 2] = LampYellow;
                end
                StAllred: lights[2*i +: 2] = LampRed;
                StFlash: begin
                    if (!r_blink) begin
                        lights[2*i +: 2] = LampOff;
                    end else if (i == 0) begin
                        lights[2*i +: 2] = LampYellow;
                    end
                end
                default: lights[2*i +: 2] = LampRed;
            endcase
        end
    end

    assign phase = r_phase;
    assign state = r_state;

endmodule

// File: tb/tb_tr_lights_multi.sv
module tb_tr_lights_multi;

    localparam int NP = 3;
    localparam int TD = 4;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;

    localparam int MG = 0;
    localparam int MY = 1;
    localparam int MA = 2;
    localparam int MF = 3;

    logic          clk;
    logic          rst;
    logic          flash_i;
    logic [NP-1:0] veh_i;
    logic [2*NP-1:0] lights;
    logic [1:0]    phase;
    logic [1:0]    state;

    int total;
    int bad;

    tr_lights_multi #(
        .N_PHASES (NP),
        .TICK_DIV (TD),
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .ALLRED_T (AT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flash   (flash_i),
        .veh_req (veh_i),
        .lights  (lights),
        .phase   (phase),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Reference model: cycles left in current dwell, counted down per clock.
    int      m_state;
    int      m_phase;
    int      m_left;
    bit      m_blink;
    bit      m_recover;
    bit [NP-1:0] m_req;

    task automatic model_reset();
        m_state   = MG;
        m_phase   = 0;
        m_left    = GT * TD;
        m_blink   = 1'b0;
        m_recover = 1'b0;
        m_req     = '0;
    endtask

    function automatic int pick_next();
        int p;
        p = (m_phase + 1) % NP;
`ifdef TRL_DEMAND_EN
        for (int k = NP; k >= 1; k--) begin
            if (m_req[(m_phase + k) % NP]) p = (m_phase + k) % NP;
        end
`endif
        return p;
    endfunction

    task automatic model_step();
        bit green_entry;
        green_entry = 1'b0;
        m_left--;
        if (m_left == 0) begin
            case (m_state)
                MG: begin m_state = MY; m_left = YT * TD; end
                MY: begin m_state = MA; m_left = AT * TD; end
                MA: begin
                    if (flash_i) begin
                        m_state = MF; m_phase = 0; m_blink = 1'b1; m_left = TD;
                    end else begin
                        m_phase = m_recover ? 0 : pick_next();
                        m_state = MG; m_left = GT * TD; green_entry = 1'b1;
                    end
                    m_recover = 1'b0;
                end
                default: begin
                    m_left = TD;
                    if (!flash_i) begin
                        m_state = MA; m_phase = 0; m_blink = 1'b0; m_recover = 1'b1;
                        m_left = AT * TD;
                    end else begin
                        m_blink = ~m_blink;
                    end
                end
            endcase
        end
`ifdef TRL_DEMAND_EN
        if (green_entry) m_req[m_phase] = 1'b0;
        m_req = m_req | veh_i;
`endif
    endtask

    function automatic logic [2*NP-1:0] exp_lights(int st, int ph, bit bl);
        logic [2*NP-1:0] l;
        l = '0;
        if (st == MF) begin
            l = bl ? 6'b000001 : 6'b111111;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (st == MG && ph == i) l[2*i +: 2] = 2'b10;
                if (st == MY && ph == i) l[2*i +: 2] = 2'b01;
            end
        end
        return l;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int nr;
        nr = 0;
        check("model_state", 8'(state), 8'(m_state));
        check("model_phase", 8'(phase), 8'(m_phase));
        check("model_lights", 8'(lights), 8'(exp_lights(m_state, m_phase, m_blink)));
        for (int i = 0; i < NP; i++) begin
            if (lights[2*i +: 2] == 2'b01 || lights[2*i +: 2] == 2'b10) nr++;
        end
        check("onehot_nonred", 8'(nr <= 1 ? 1 : 0), 8'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        int         n;
        bit         fl;
        logic [1:0] st;
        logic [1:0] ph;
        logic [5:0] li;
    } vec_t;

    vec_t tbl[18];

`ifdef TRL_DEMAND_EN
    localparam int Ph32 = 2;
    localparam int Ph64 = 0;
`else
    localparam int Ph32 = 1;
    localparam int Ph64 = 2;
`endif

    initial begin
        bit found;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        flash_i = 1'b0;
        veh_i   = '0;
        model_reset();

        tbl[0]  = '{19, 1'b0, 2'd0, 2'd0, 6'b000010};
        tbl[1]  = '{1,  1'b0, 2'd1, 2'd0, 6'b000001};
        tbl[2]  = '{7,  1'b0, 2'd1, 2'd0, 6'b000001};
        tbl[3]  = '{1,  1'b0, 2'd2, 2'd0, 6'b000000};
        tbl[4]  = '{4,  1'b0, 2'd0, 2'd1, 6'b001000};
        tbl[5]  = '{64, 1'b0, 2'd0, 2'd0, 6'b000010};
        tbl[6]  = '{32, 1'b0, 2'd0, 2'd1, 6'b001000};
        tbl[7]  = '{10, 1'b1, 2'd0, 2'd1, 6'b001000};
        tbl[8]  = '{10, 1'b1, 2'd1, 2'd1, 6'b000100};
        tbl[9]  = '{8,  1'b1, 2'd2, 2'd1, 6'b000000};
        tbl[10] = '{4,  1'b1, 2'd3, 2'd0, 6'b000001};
        tbl[11] = '{4,  1'b1, 2'd3, 2'd0, 6'b111111};
        tbl[12] = '{4,  1'b1, 2'd3, 2'd0, 6'b000001};
        tbl[13] = '{2,  1'b0, 2'd3, 2'd0, 6'b000001};
        tbl[14] = '{2,  1'b0, 2'd2, 2'd0, 6'b000000};
        tbl[15] = '{3,  1'b0, 2'd2, 2'd0, 6'b000000};
        tbl[16] = '{1,  1'b0, 2'd0, 2'd0, 6'b000010};
        tbl[17] = '{32, 1'b0, 2'd0, 2'd1, 6'b001000};

        repeat (2) @(negedge clk);
        check("rst_state", 8'(state), 8'd0);
        check("rst_phase", 8'(phase), 8'd0);
        check("rst_lights", 8'(lights), 8'b000010);

        rst = 1'b0;
        model_reset();

        for (int v = 0; v < 18; v++) begin
            flash_i = tbl[v].fl;
            veh_i   = '0;
            for (int c = 0; c < tbl[v].n; c++) cyc();
            check($sformatf("tbl%0d_state", v), 8'(state), 8'(tbl[v].st));
            check($sformatf("tbl%0d_phase", v), 8'(phase), 8'(tbl[v].ph));
            check($sformatf("tbl%0d_lights", v), 8'(lights), 8'(tbl[v].li));
        end

        // Randomized run against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 2) flash_i = ~flash_i;
            veh_i = ($urandom_range(0, 9) == 0) ? NP'($urandom_range(0, 7)) : '0;
            cyc();
        end

        // Reset mid-YELLOW
        flash_i = 1'b0;
        veh_i   = '0;
        found   = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            cyc();
            if (state === 2'b01) found = 1'b1;
        end
        check("reach_yellow", 8'(found), 8'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_state", 8'(state), 8'd0);
        check("async_rst_phase", 8'(phase), 8'd0);
        check("async_rst_lights", 8'(lights), 8'b000010);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Full green after release; demand pulse for phase 2 during phase 0 green
        veh_i = 3'b100;
        cyc();
        veh_i = '0;
        repeat (18) cyc();
        check("post_rst_green", 8'(state), 8'd0);
        cyc();
        check("post_rst_yellow", 8'(state), 8'd1);
        repeat (12) cyc();
        check("c32_state", 8'(state), 8'd0);
        check("c32_phase", 8'(phase), 8'(Ph32));
        repeat (32) cyc();
        check("c64_state", 8'(state), 8'd0);
        check("c64_phase", 8'(phase), 8'(Ph64));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
